// File: rtl/register_writeback_queue_pkg.sv
// Shared pipeline definitions for the register writeback queue: default sizes and the queued entry.
package register_writeback_queue_pkg;

   localparam int unsigned WB_DEPTH  = 4;
   localparam int unsigned WB_DATA_W = 32;
   localparam int unsigned WB_ADDR_W = 5;

   typedef struct packed {
      logic [WB_ADDR_W-1:0] address;
      logic [WB_DATA_W-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/register_writeback_queue_if.sv
// Producer/consumer bundle of the writeback queue: ALU and load offers, register-file write, bypass lookups.
interface register_writeback_queue_if
   import register_writeback_queue_pkg::*;
#(
   parameter int unsigned DEPTH      = WB_DEPTH,
   parameter int unsigned DATA_WIDTH = WB_DATA_W,
   parameter int unsigned ADDR_WIDTH = WB_ADDR_W
) ();

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic                  aluValid;
   logic [ADDR_WIDTH-1:0] aluAddress;
   logic [DATA_WIDTH-1:0] aluData;
   logic                  aluReady;
   logic                  loadValid;
   logic [ADDR_WIDTH-1:0] loadAddress;
   logic [DATA_WIDTH-1:0] loadData;
   logic                  loadReady;
   logic                  regWriteEnable;
   logic [ADDR_WIDTH-1:0] regWriteAddress;
   logic [DATA_WIDTH-1:0] regWriteData;
   logic [ADDR_WIDTH-1:0] lookupAddress1;
   logic [ADDR_WIDTH-1:0] lookupAddress2;
   logic                  lookupHit1;
   logic                  lookupHit2;
   logic [DATA_WIDTH-1:0] lookupData1;
   logic [DATA_WIDTH-1:0] lookupData2;
   logic [CNT_W-1:0]      count;
   logic                  full;
   logic                  empty;

   modport master (
      output aluValid, aluAddress, aluData, loadValid, loadAddress, loadData,
             lookupAddress1, lookupAddress2,
      input  aluReady, loadReady, regWriteEnable, regWriteAddress, regWriteData,
             lookupHit1, lookupHit2, lookupData1, lookupData2, count, full, empty
   );

   modport slave (
      input  aluValid, aluAddress, aluData, loadValid, loadAddress, loadData,
             lookupAddress1, lookupAddress2,
      output aluReady, loadReady, regWriteEnable, regWriteAddress, regWriteData,
             lookupHit1, lookupHit2, lookupData1, lookupData2, count, full, empty
   );

endinterface

// File: rtl/register_writeback_queue_lookup.sv
// Newest-match bypass search over the occupied window of the writeback queue.
module writeback_lookup
   import register_writeback_queue_pkg::*;
#(
   parameter int unsigned DEPTH      = WB_DEPTH,
   parameter int unsigned DATA_WIDTH = WB_DATA_W,
   parameter int unsigned ADDR_WIDTH = WB_ADDR_W,
   localparam int unsigned PTR_W     = $clog2(DEPTH),
   localparam int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
   input  wb_entry_t [DEPTH-1:0] entries_i,
   input  logic [PTR_W-1:0]      head_i,
   input  logic [CNT_W-1:0]      count_i,
   input  logic                  enable_i,
   input  logic [ADDR_WIDTH-1:0] query_i,
   output logic                  hit_o,
   output logic [DATA_WIDTH-1:0] data_o
);

   logic [PTR_W-1:0] idx;

   // Walk oldest to newest so a later (newer) match overrides an earlier one.
   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      idx    = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = head_i + PTR_W'(i);
         if (enable_i && (query_i != '0) && (CNT_W'(i) < count_i) &&
             (ADDR_WIDTH'(entries_i[idx].address) == query_i)) begin
            hit_o  = 1'b1;
            data_o = DATA_WIDTH'(entries_i[idx].data);
         end
      end
   end

endmodule

// File: rtl/register_writeback_queue.sv
// Circular writeback queue merging ALU and load results into one register-file write port with bypass lookups.
module register_writeback_queue
   import register_writeback_queue_pkg::*;
#(
   parameter int unsigned DEPTH      = WB_DEPTH,
   parameter int unsigned DATA_WIDTH = WB_DATA_W,
   parameter int unsigned ADDR_WIDTH = WB_ADDR_W
) (
   input logic clock,
   input logic reset,
   register_writeback_queue_if.slave wb
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   wb_entry_t [DEPTH-1:0] mem_q;
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [CNT_W-1:0]      count_q, count_d;

   logic [CNT_W-1:0] free_c;
   logic [CNT_W-1:0] n_enq_c;
   logic [PTR_W-1:0] alu_slot_c;
   logic             load_ready_c, alu_ready_c;
   logic             load_enq_c, alu_enq_c, deq_c;
   wb_entry_t        load_entry_c, alu_entry_c;

   assign free_c       = CNT_W'(DEPTH) - count_q;
   assign load_ready_c = !reset && (count_q != CNT_W'(DEPTH));
   assign alu_ready_c  = !reset && ((free_c >= CNT_W'(2)) ||
                                    ((free_c == CNT_W'(1)) && !wb.loadValid));
   // Writes to $zero complete the handshake but never occupy a slot.
   assign load_enq_c   = wb.loadValid && load_ready_c && (wb.loadAddress != '0);
   assign alu_enq_c    = wb.aluValid && alu_ready_c && (wb.aluAddress != '0);
   assign deq_c        = !reset && (count_q != '0);

   assign load_entry_c = '{address: WB_ADDR_W'(wb.loadAddress), data: WB_DATA_W'(wb.loadData)};
   assign alu_entry_c  = '{address: WB_ADDR_W'(wb.aluAddress), data: WB_DATA_W'(wb.aluData)};

   // Load is older than a same-cycle ALU result, so it takes the first free slot.
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      n_enq_c    = CNT_W'(load_enq_c) + CNT_W'(alu_enq_c);
      alu_slot_c = tail_q + PTR_W'(load_enq_c);
      if (deq_c) begin
         head_d = head_q + PTR_W'(1);
      end
      tail_d  = tail_q + PTR_W'(n_enq_c);
      count_d = count_q + n_enq_c - CNT_W'(deq_c);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (load_enq_c) begin
            mem_q[tail_q] <= load_entry_c;
         end
         if (alu_enq_c) begin
            mem_q[alu_slot_c] <= alu_entry_c;
         end
      end
   end

   assign wb.loadReady       = load_ready_c;
   assign wb.aluReady        = alu_ready_c;
   assign wb.regWriteEnable  = deq_c;
   assign wb.regWriteAddress = deq_c ? ADDR_WIDTH'(mem_q[head_q].address) : '0;
   assign wb.regWriteData    = deq_c ? DATA_WIDTH'(mem_q[head_q].data) : '0;
   assign wb.count           = count_q;
   assign wb.full            = (count_q == CNT_W'(DEPTH));
   assign wb.empty           = (count_q == '0);

   writeback_lookup #(
      .DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
   ) u_lookup1 (
      .entries_i (mem_q),
      .head_i    (head_q),
      .count_i   (count_q),
      .enable_i  (!reset),
      .query_i   (wb.lookupAddress1),
      .hit_o     (wb.lookupHit1),
      .data_o    (wb.lookupData1)
   );

   writeback_lookup #(
      .DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
   ) u_lookup2 (
      .entries_i (mem_q),
      .head_i    (head_q),
      .count_i   (count_q),
      .enable_i  (!reset),
      .query_i   (wb.lookupAddress2),
      .hit_o     (wb.lookupHit2),
      .data_o    (wb.lookupData2)
   );

endmodule

// File: tb/tb_register_writeback_queue.sv
// Scoreboard bench for register_writeback_queue: directed scenarios plus randomized traffic against a queue model.
module tb_register_writeback_queue;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 5;
   localparam int unsigned DW    = 32;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   logic clock;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   ent_t model_q[$];
   ent_t exp_q[$];

   register_writeback_queue_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   register_writeback_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clock (clock),
      .reset (reset),
      .wb    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Newest pending entry for an address; $zero never hits.
   task automatic model_lookup(input logic [AW-1:0] q, output bit hit, output logic [DW-1:0] d);
      hit = 1'b0;
      d   = '0;
      if (q != '0) begin
         for (int i = model_q.size() - 1; i >= 0; i--) begin
            if (!hit && model_q[i].a == q) begin
               hit = 1'b1;
               d   = model_q[i].d;
            end
         end
      end
   endtask

   task automatic step(input bit rst, input bit lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                       input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic [AW-1:0] q1, input logic [AW-1:0] q2);
      int            n;
      int            free;
      bit            exp_lr, exp_ar, h1, h2;
      logic [DW-1:0] d1, d2;
      ent_t          e;
      @(posedge clock);
      #1;
      reset              = rst;
      bus.loadValid      = lv;
      bus.loadAddress    = la;
      bus.loadData       = ld;
      bus.aluValid       = av;
      bus.aluAddress     = aa;
      bus.aluData        = ad;
      bus.lookupAddress1 = q1;
      bus.lookupAddress2 = q2;
      #2;
      n      = model_q.size();
      free   = DEPTH - n;
      exp_lr = !rst && (free > 0);
      exp_ar = !rst && ((free >= 2) || (free == 1 && !lv));
      chk("loadReady", 32'(bus.loadReady), 32'(exp_lr));
      chk("aluReady", 32'(bus.aluReady), 32'(exp_ar));
      chk("count", 32'(bus.count), 32'(n));
      chk("empty", 32'(bus.empty), 32'(n == 0));
      chk("full", 32'(bus.full), 32'(n == DEPTH));
      chk("regWriteEnable", 32'(bus.regWriteEnable), 32'(!rst && n > 0));
      if (rst) begin
         chk("lookupHit1_rst", 32'(bus.lookupHit1), 32'(0));
         chk("lookupHit2_rst", 32'(bus.lookupHit2), 32'(0));
         model_q.delete();
         exp_q.delete();
      end else begin
         if (n == 0) begin
            chk("idleAddr", 32'(bus.regWriteAddress), 32'(0));
            chk("idleData", bus.regWriteData, 32'(0));
         end
         model_lookup(q1, h1, d1);
         model_lookup(q2, h2, d2);
         chk("lookupHit1", 32'(bus.lookupHit1), 32'(h1));
         chk("lookupData1", bus.lookupData1, d1);
         chk("lookupHit2", 32'(bus.lookupHit2), 32'(h2));
         chk("lookupData2", bus.lookupData2, d2);
         if (n > 0) void'(model_q.pop_front());
         if (lv && exp_lr && la != '0) begin
            e.a = la; e.d = ld;
            model_q.push_back(e);
            exp_q.push_back(e);
         end
         if (av && exp_ar && aa != '0) begin
            e.a = aa; e.d = ad;
            model_q.push_back(e);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic idle(input logic [AW-1:0] q1, input logic [AW-1:0] q2);
      step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, q1, q2);
   endtask

   // Monitor: every observed write must be the oldest expected entry.
   initial begin
      ent_t e;
      forever begin
         @(negedge clock);
         if (bus.regWriteEnable === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write actual=%0h:%0h required=none at %0t",
                        bus.regWriteAddress, bus.regWriteData, $time);
            end else begin
               e = exp_q.pop_front();
               if (bus.regWriteAddress !== e.a || bus.regWriteData !== e.d) begin
                  errors++;
                  $display("FAIL write_order actual=%0h:%0h required=%0h:%0h at %0t",
                           bus.regWriteAddress, bus.regWriteData, e.a, e.d, $time);
               end
            end
         end
      end
   end

   initial begin
      reset              = 1'b1;
      bus.loadValid      = 1'b0;
      bus.loadAddress    = '0;
      bus.loadData       = '0;
      bus.aluValid       = 1'b0;
      bus.aluAddress     = '0;
      bus.aluData        = '0;
      bus.lookupAddress1 = '0;
      bus.lookupAddress2 = '0;

      step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 5'd0, 5'd0);
      idle(5'd5, 5'd3);

      // Single load through an empty queue: one-cycle latency.
      step(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, '0, '0, 5'd5, 5'd0);
      idle(5'd5, 5'd1);
      idle(5'd5, 5'd1);

      // Same-cycle load and ALU to r3: load written first, lookup sees the ALU value.
      step(1'b0, 1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB, 5'd3, 5'd3);
      idle(5'd3, 5'd4);
      chk("r3_bypass_newest", bus.lookupData1, 32'hB);
      idle(5'd3, 5'd4);
      idle(5'd3, 5'd4);

      // Fill to three, then offer both with one slot free.
      step(1'b0, 1'b1, 5'd7, 32'h70, 1'b1, 5'd8, 32'h80, 5'd7, 5'd8);
      step(1'b0, 1'b1, 5'd9, 32'h90, 1'b1, 5'd10, 32'hA0, 5'd9, 5'd10);
      step(1'b0, 1'b1, 5'd11, 32'hB0, 1'b1, 5'd12, 32'hC0, 5'd11, 5'd12);
      chk("alu_held_off", 32'(bus.aluReady), 32'(0));
      step(1'b0, 1'b0, '0, '0, 1'b1, 5'd12, 32'hC0, 5'd12, 5'd10);
      for (int i = 0; i < 5; i++) idle(5'd12, 5'd11);

      // Discarded write to $zero.
      step(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF, 5'd0, 5'd0);
      idle(5'd0, 5'd0);

      // Reset with three entries pending.
      step(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 5'd1, 5'd2);
      step(1'b0, 1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 5'd3, 5'd4);
      step(1'b1, 1'b1, 5'd5, 32'h55, 1'b0, '0, '0, 5'd3, 5'd4);
      idle(5'd3, 5'd4);
      idle(5'd1, 5'd2);

      // Back-to-back offers long enough to wrap the pointers.
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1, AW'(i % 7 + 1), DW'(32'h100 + i),
              (i % 3) == 0, AW'(i % 5 + 9), DW'(32'h200 + i), AW'(i % 7 + 1), AW'(i % 5 + 9));
      end
      for (int i = 0; i < 6; i++) idle(5'd1, 5'd9);

      // Randomized traffic with address collisions, $zero writes and occasional reset.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
              $urandom, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
              AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      end
      for (int i = 0; i < 6; i++) idle(5'd2, 5'd6);
      chk("drained", 32'(exp_q.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/register_writeback_queue.md
REGISTER_WRITEBACK_QUEUE -- requirements
Module: register_writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of pending write entries (power of two, >=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 5, register address width (32 registers).
REQ-004 SHALL have ports, one per line: name, direction, width, meaning.
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- aluValid  in  1  ALU result offered.
- aluAddress  in  ADDR_WIDTH  ALU destination register.
- aluData  in  DATA_WIDTH  ALU result.
- aluReady  out  1  ALU offer accepted this cycle.
- loadValid  in  1  load result offered.
- loadAddress  in  ADDR_WIDTH  load destination register.
- loadData  in  DATA_WIDTH  load result.
- loadReady  out  1  load offer accepted this cycle.
- regWriteEnable  out  1  register-file write strobe.
- regWriteAddress  out  ADDR_WIDTH  register-file write address.
- regWriteData  out  DATA_WIDTH  register-file write data.
- lookupAddress1 / lookupAddress2  in  ADDR_WIDTH  bypass query addresses.
- lookupHit1 / lookupHit2  out  1  query matches a pending entry.
- lookupData1 / lookupData2  out  DATA_WIDTH  newest pending data for query; 0 on miss.
- count  out  log2(DEPTH)+1  occupied entries.
- full / empty  out  1  count==DEPTH / count==0.

Function
REQ-005 SHALL implement a circular FIFO of {address, data} entries with head/tail pointers wrapping modulo DEPTH.
REQ-006 SHALL complete a handshake on a source when valid and ready are both high at a rising edge.
REQ-007 SHALL drive loadReady = !full, using count before any same-cycle dequeue.
REQ-008 SHALL drive aluReady high when free slots >=2, or free slots ==1 and loadValid low; else low.
REQ-009 SHALL, on simultaneous acceptance, enqueue the load entry first (older), then the ALU entry.
REQ-010 SHALL accept, but not enqueue, any offer whose address is 0 (write to $zero discarded).
REQ-011 SHALL, whenever not empty, present the head entry on regWriteAddress/regWriteData with regWriteEnable high, and dequeue it at that edge (one write per cycle, no backpressure).
REQ-012 SHALL drive regWriteEnable low and regWriteAddress/regWriteData to 0 when empty.
REQ-013 SHALL give latency of exactly one cycle from acceptance to write strobe when the queue was empty; FIFO order otherwise.
REQ-014 SHALL update count by (+enqueues - dequeue) in one cycle, including enqueue of 2 with dequeue of 1.
REQ-015 SHALL compute lookups combinationally over all occupied entries, including the head being written this cycle; the newest match wins.
REQ-016 SHALL never hit on lookup address 0, and SHALL ignore entries offered but not yet enqueued.

Reset
REQ-017 SHALL, when reset is high at an edge, clear pointers and count and discard all pending entries.
REQ-018 SHALL force aluReady, loadReady, regWriteEnable and lookup hits low combinationally while reset is high, including reset asserted mid-drain.
REQ-019 SHALL present after reset: count=0, empty=1, full=0, regWriteEnable=0, write address/data 0, lookupData 0.

Structure
REQ-020 SHALL take DEPTH/width defaults and the writeback entry struct {address, data} from a shared pipeline package.
REQ-021 SHALL implement the newest-match search as one sub-module, writeback_lookup, instantiated twice.

Verification
REQ-022 Empty queue, loadValid with r5=0x1234 -> loadReady=1; next cycle regWriteEnable=1, addr 5, data 0x1234; count returns to 0.
REQ-023 Same cycle load r3=0xA, ALU r3=0xB -> writes r3=0xA, then r3=0xB on consecutive cycles; lookup r3 returns 0xB while both are pending.
REQ-024 Fill to count=3 (DEPTH=4), offer both sources -> loadReady=1, aluReady=0; count=4 after the edge less one dequeue (=3); ALU entry accepted next cycle.
REQ-025 ALU offer to r0=0xFFFF -> aluReady=1, no write strobe, count unchanged, lookup r0 misses.
REQ-026 Reset asserted with 3 entries pending -> regWriteEnable low during reset; after release empty=1, no remaining writes.
REQ-027 Continuous back-to-back offers for 10 cycles with pointer wrap -> write order and data match offer order exactly.
